// File: rtl/mem_access_unit.sv
// Load/store front end: turns byte/half/word requests into word-aligned memory accesses (RMW for sub-word stores).
// Latency: fault 1, word store 2, load 3, sub-word store 4 cycles; ready=0 (requests ignored) while busy.
module mem_access_unit #(
  parameter int ADDR_W    = 32,
  parameter int MEM_WORDS = 200
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              ready,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              fault,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rd
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, FIN} state_t;

  localparam logic [ADDR_W-3:0] WORD_LIMIT = (ADDR_W-2)'(MEM_WORDS);

  state_t      state_q, state_d;
  logic        we_q, uns_q, fault_q;
  logic [1:0]  size_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q;
  logic        req_fault;
  logic [4:0]  sh;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_val, lane_mask, merge_val;

  always_comb begin
    req_fault = 1'b0;
    case (req_size)
      2'b01:   req_fault = req_addr[0];
      2'b10:   req_fault = |req_addr[1:0];
      2'b11:   req_fault = 1'b1;
      default: req_fault = 1'b0;
    endcase
    if (req_addr[ADDR_W-1:2] >= WORD_LIMIT) req_fault = 1'b1;
  end

  // Half accesses are already known to have lane_q[0]=0, so one shift serves both sizes.
  assign sh      = {lane_q, 3'b000};
  assign rd_byte = 8'(mem_rd >> sh);
  assign rd_half = 16'(mem_rd >> sh);

  always_comb begin
    load_val = mem_rd;
    case (size_q)
      2'b00:   load_val = uns_q ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      2'b01:   load_val = uns_q ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: load_val = mem_rd;
    endcase
  end

  assign lane_mask = size_q[0] ? 32'h0000_FFFF : 32'h0000_00FF;
  assign merge_val = (mem_rd & ~(lane_mask << sh)) | ((wdata_q & lane_mask) << sh);

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    done    = 1'b0;
    fault   = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (req) begin
          if (req_fault)                       state_d = FIN;
          else if (req_we && req_size == 2'b10) state_d = WR;
          else                                 state_d = RD;
        end
      end
      RD:  state_d = CAP;
      CAP: state_d = we_q ? WR : FIN;
      WR: begin
        mem_we  = 1'b1;
        state_d = FIN;
      end
      FIN: begin
        done    = 1'b1;
        fault   = fault_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      fault_q   <= 1'b0;
      size_q    <= 2'b00;
      lane_q    <= 2'b00;
      wdata_q   <= 32'b0;
      rdata     <= 32'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        size_q  <= req_size;
        lane_q  <= req_addr[1:0];
        wdata_q <= req_wdata;
        fault_q <= req_fault;
        // A faulting request leaves the memory-facing registers untouched.
        if (!req_fault) begin
          mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
          mem_wdata <= req_wdata;
        end
      end
      if (state_q == CAP) begin
        if (we_q) mem_wdata <= merge_val;
        else      rdata     <= load_val;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, hand-written reset/busy sequences, and random traffic against a byte-array model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = 32'b0, req_wdata = 32'b0;
  logic        ready, done, fault, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rd = 32'b0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32), .MEM_WORDS(200)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .ready(ready), .done(done), .rdata(rdata), .fault(fault),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd)
  );

  // Word memory; tb_we is a backdoor port used only for preloading.
  logic [31:0] mem [0:255];
  logic        tb_we = 1'b0;
  logic [7:0]  tb_idx = 8'd0;
  logic [31:0] tb_dat = 32'b0;
  always @(posedge clk) begin
    if (tb_we)       mem[tb_idx] <= tb_dat;
    else if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    if (!mem_we)     mem_rd <= mem[mem_addr[9:2]];
  end

  // Reference model: flat little-endian byte array.
  logic [7:0]  ref_b [0:1023];
  logic [31:0] model_rdata;
  int          pass_cnt = 0, total_cnt = 0;

  function automatic logic [31:0] ref_word(input int w);
    return {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic poke(input int w, input logic [31:0] d);
    tb_we = 1'b1; tb_idx = 8'(w); tb_dat = d;
    @(posedge clk); #1;
    tb_we = 1'b0;
    for (int i = 0; i < 4; i++) ref_b[4*w+i] = d[8*i +: 8];
  endtask

  // Issue one request and return the done cycle (-1 on timeout), fault, rdata and mem_we cycle count.
  task automatic run(input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] a, input logic [31:0] wd,
                     output int n, output logic flt, output logic [31:0] rd, output int wes);
    int guard;
    n = -1; flt = 1'b0; rd = 32'b0; wes = 0; guard = 0;
    @(negedge clk);
    while (!ready && guard < 20) begin @(negedge clk); guard++; end
    req = 1'b1; req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (mem_we) wes++;
      if (done) begin n = k; flt = fault; rd = rdata; break; end
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic we; logic [1:0] size; logic uns; logic [31:0] addr; logic [31:0] wdata;
    int exp_n; logic exp_flt; logic chk_rd; logic [31:0] exp_rd; logic chk_word; logic [31:0] exp_word;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [1:0] sz, input logic uns,
                              input logic [31:0] a, input logic [31:0] wd, input int n,
                              input logic flt, input logic crd, input logic [31:0] erd,
                              input logic cw, input logic [31:0] ew);
    vec_t v;
    v.we = we; v.size = sz; v.uns = uns; v.addr = a; v.wdata = wd; v.exp_n = n; v.exp_flt = flt;
    v.chk_rd = crd; v.exp_rd = erd; v.chk_word = cw; v.exp_word = ew;
    return v;
  endfunction

  vec_t tbl [12];

  initial begin
    int n, wes;
    logic flt;
    logic [31:0] rd;

    tbl[0]  = mk(1, 2'b10, 0, 32'h10,  32'hDEADBEEF, 2, 0, 0, 0,            1, 32'hDEADBEEF);
    tbl[1]  = mk(0, 2'b10, 0, 32'h10,  32'h0,        3, 0, 1, 32'hDEADBEEF, 0, 0);
    tbl[2]  = mk(0, 2'b00, 0, 32'h23,  32'h0,        3, 0, 1, 32'hFFFFFF80, 0, 0);
    tbl[3]  = mk(0, 2'b00, 1, 32'h23,  32'h0,        3, 0, 1, 32'h00000080, 0, 0);
    tbl[4]  = mk(0, 2'b01, 0, 32'h22,  32'h0,        3, 0, 1, 32'hFFFF80FF, 0, 0);
    tbl[5]  = mk(0, 2'b01, 1, 32'h20,  32'h0,        3, 0, 1, 32'h00007F01, 0, 0);
    tbl[6]  = mk(1, 2'b00, 0, 32'h31,  32'hFFFFFFAB, 4, 0, 0, 0,            1, 32'h1122AB44);
    tbl[7]  = mk(1, 2'b01, 0, 32'h32,  32'h9999CDEF, 4, 0, 0, 0,            1, 32'hCDEFAB44);
    tbl[8]  = mk(0, 2'b10, 0, 32'h32,  32'h0,        1, 1, 1, 32'h00007F01, 1, 32'hCDEFAB44);
    tbl[9]  = mk(1, 2'b01, 0, 32'h05,  32'h1234,     1, 1, 1, 32'h00007F01, 0, 0);
    tbl[10] = mk(0, 2'b10, 0, 32'h320, 32'h0,        1, 1, 1, 32'h00007F01, 0, 0);
    tbl[11] = mk(1, 2'b11, 0, 32'h40,  32'h55,       1, 1, 1, 32'h00007F01, 0, 0);

    // Preload during reset; clocks run so the backdoor port works.
    for (int w = 0; w < 256; w++) poke(w, $urandom);
    poke(8,  32'h80FF7F01);
    poke(12, 32'h11223344);
    poke(13, 32'h55667788);

    chk("rst_ready", {31'b0, ready}, 32'd1);
    chk("rst_done",  {31'b0, done},  32'd0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);

    @(negedge clk); rst_n = 1'b1;
    model_rdata = 32'b0;

    for (int i = 0; i < 12; i++) begin
      run(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata, n, flt, rd, wes);
      chk($sformatf("v%0d_latency", i), n, tbl[i].exp_n);
      chk($sformatf("v%0d_fault", i), {31'b0, flt}, {31'b0, tbl[i].exp_flt});
      chk($sformatf("v%0d_we_cycles", i), wes, (tbl[i].we && !tbl[i].exp_flt) ? 1 : 0);
      if (tbl[i].chk_rd)   chk($sformatf("v%0d_rdata", i), rd, tbl[i].exp_rd);
      if (tbl[i].chk_word) chk($sformatf("v%0d_memword", i), mem[tbl[i].addr[9:2]], tbl[i].exp_word);
      if (tbl[i].we && !tbl[i].exp_flt)
        for (int b = 0; b < 4; b++) ref_b[{tbl[i].addr[31:2], 2'b00} + b] = mem[tbl[i].addr[9:2]][8*b +: 8];
    end
    model_rdata = 32'h00007F01;

    // Reset while an sb sits in WR: mem_we must drop asynchronously and the write must not land.
    begin
      int k;
      @(negedge clk);
      req = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h35; req_wdata = 32'hEE;
      @(posedge clk); @(negedge clk); req = 1'b0;
      k = 1;
      while (!mem_we && k < 10) begin @(negedge clk); k++; end
      chk("midrst_wr_cycle", k, 3);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_mem_we", {31'b0, mem_we}, 32'd0);
      chk("midrst_ready", {31'b0, ready}, 32'd1);
      @(negedge clk); rst_n = 1'b1;
      n = 0;
      for (int c = 0; c < 6; c++) begin if (done) n++; @(negedge clk); end
      chk("midrst_no_done", n, 0);
      chk("midrst_ready_after", {31'b0, ready}, 32'd1);
      chk("midrst_mem_intact", mem[13], ref_word(13));
      chk("midrst_rdata_cleared", rdata, 32'd0);
      model_rdata = 32'b0;
    end

    // Busy: req held high with changing addresses; only the first and the one at ready=1 are served.
    begin
      int first_n;
      first_n = -1;
      @(negedge clk);
      req = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h10;
      @(posedge clk);
      for (int k = 1; k <= 3; k++) begin
        @(negedge clk);
        if (done && first_n < 0) first_n = k;
        req_addr = (k == 3) ? 32'h20 : 32'h30 + 32'(4*k);
      end
      chk("busy_first_latency", first_n, 3);
      chk("busy_first_rdata", rdata, ref_word(4));
      @(negedge clk);
      chk("busy_ready_after_fin", {31'b0, ready}, 32'd1);
      @(posedge clk); @(negedge clk); req = 1'b0;
      n = -1;
      for (int k = 1; k <= 10; k++) begin
        if (done) begin n = k; break; end
        @(negedge clk);
      end
      chk("busy_second_latency", n, 3);
      chk("busy_second_rdata", rdata, ref_word(8));
      model_rdata = ref_word(8);
    end

    // Random traffic against the byte-array model.
    for (int it = 0; it < 300; it++) begin
      logic        we, uns, eflt;
      logic [1:0]  sz;
      logic [31:0] a, wd, erd;
      int          en, wi;
      we = 1'($urandom); uns = 1'($urandom); sz = 2'($urandom);
      a = $urandom_range(0, 1023); wd = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      wi = int'(a >> 2);
      eflt = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00) || (wi >= 200);
      en = eflt ? 1 : (we && sz == 2'b10) ? 2 : we ? 4 : 3;
      erd = model_rdata;
      if (!eflt && !we) begin
        if (sz == 2'b00)      erd = uns ? 32'(ref_b[a]) : 32'($signed(ref_b[a]));
        else if (sz == 2'b01) erd = uns ? 32'({ref_b[a+1], ref_b[a]}) : 32'($signed({ref_b[a+1], ref_b[a]}));
        else                  erd = ref_word(wi);
      end
      if (!eflt && we) begin
        ref_b[a] = wd[7:0];
        if (sz != 2'b00) ref_b[a+1] = wd[15:8];
        if (sz == 2'b10) begin ref_b[a+2] = wd[23:16]; ref_b[a+3] = wd[31:24]; end
      end
      run(we, sz, uns, a, wd, n, flt, rd, wes);
      chk($sformatf("rnd%0d_latency", it), n, en);
      chk($sformatf("rnd%0d_fault", it), {31'b0, flt}, {31'b0, eflt});
      chk($sformatf("rnd%0d_rdata", it), rd, erd);
      chk($sformatf("rnd%0d_we_cycles", it), wes, (we && !eflt) ? 1 : 0);
      if (wi < 256) chk($sformatf("rnd%0d_memword", it), mem[wi], ref_word(wi));
      model_rdata = erd;
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
